// File: rtl/cpu_bus_responder_if.sv
// CPU data-bus, PRG-ROM and PPU register-port signals seen by the bus responder.
// The slave modport is the responder's view; master is the CPU/ROM/PPU environment.
interface cpu_bus_responder_if #(
    parameter int PRG_AW = 15
) ();
    logic              busValid;
    logic [15:0]       addr;
    logic              wrEn;
    logic [7:0]        dataWr;
    logic [7:0]        dataRd;
    logic              rdy;
    logic              busErr;
    logic [PRG_AW-1:0] prgAddr;
    logic [7:0]        prgData;
    logic              ppuReq;
    logic [2:0]        ppuAddr;
    logic              ppuWrEn;
    logic [7:0]        ppuDataWr;
    logic [7:0]        ppuDataRd;
    logic              ppuAck;

    modport slave (
        input  busValid, addr, wrEn, dataWr, prgData, ppuDataRd, ppuAck,
        output dataRd, rdy, busErr, prgAddr, ppuReq, ppuAddr, ppuWrEn, ppuDataWr
    );

    modport master (
        output busValid, addr, wrEn, dataWr, prgData, ppuDataRd, ppuAck,
        input  dataRd, rdy, busErr, prgAddr, ppuReq, ppuAddr, ppuWrEn, ppuDataWr
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: RAM/PRG/unmapped complete with rdy one cycle after accept, PPU one cycle after ack/timeout.
// The CPU holds its request until rdy; busValid is only sampled in IDLE, so accesses are at least 2 cycles apart.
module cpu_bus_responder #(
    parameter int RAM_AW      = 11,
    parameter int PRG_AW      = 15,
    parameter int PPU_TIMEOUT = 255
) (
    input  logic                 cpuClk,
    input  logic                 reset,
    cpu_bus_responder_if.slave   bus
);
    localparam int CW = $clog2(PPU_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_PPU_WAIT, S_RESP} state_t;
    localparam logic [1:0] SRC_RAM = 2'd0;
    localparam logic [1:0] SRC_PRG = 2'd1;
    localparam logic [1:0] SRC_LAT = 2'd2;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_src;
    logic                r_wr;
    logic [7:0]          r_wdat;
    logic [7:0]          r_lat;
    logic [7:0]          r_openBus;
    logic [7:0]          r_ramQ;
    logic                r_err;
    logic [CW-1:0]       r_cnt;
    logic                r_ppuReq;
    logic [2:0]          r_ppuAddr;
    logic                r_ppuWrEn;
    logic [7:0]          r_ppuDataWr;
    logic [7:0]          r_ram [0:(1<<RAM_AW)-1];

    logic                w_isRam;
    logic                w_isPpu;
    logic                w_isPrg;
    logic                w_accept;
    logic                w_timeout;
    logic [RAM_AW-1:0]   w_ramIdx;
    logic [7:0]          w_rdata;
    logic                w_rdy;
    logic                w_busErr;
    logic [7:0]          w_dataRd;

    assign w_isRam   = (bus.addr[15:13] == 3'b000);
    assign w_isPpu   = (bus.addr[15:13] == 3'b001);
    assign w_isPrg   = bus.addr[15];
    assign w_accept  = (r_state == S_IDLE) && bus.busValid;
    assign w_timeout = (r_cnt == CW'(PPU_TIMEOUT - 1));
    assign w_ramIdx  = bus.addr[RAM_AW-1:0];

    always_ff @(posedge cpuClk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // An ack sampled in the timeout cycle takes priority over the forced completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.busValid) w_next = w_isPpu ? S_PPU_WAIT : S_RESP;
            S_PPU_WAIT: if (bus.ppuAck || w_timeout) w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdy    = 1'b0;
        w_busErr = 1'b0;
        w_dataRd = 8'h00;
        if (r_state == S_RESP) begin
            w_rdy    = 1'b1;
            w_busErr = r_err;
            if (!r_wr) w_dataRd = w_rdata;
        end
    end

    always_comb begin
        w_rdata = r_lat;
        case (r_src)
            SRC_RAM: w_rdata = r_ramQ;
            SRC_PRG: w_rdata = bus.prgData;
            default: w_rdata = r_lat;
        endcase
    end

    always_ff @(posedge cpuClk or negedge reset) begin
        if (!reset) begin
            r_src       <= SRC_LAT;
            r_wr        <= 1'b0;
            r_wdat      <= 8'h00;
            r_lat       <= 8'h00;
            r_openBus   <= 8'h00;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_ppuReq    <= 1'b0;
            r_ppuAddr   <= 3'd0;
            r_ppuWrEn   <= 1'b0;
            r_ppuDataWr <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: if (bus.busValid) begin
                    r_wr   <= bus.wrEn;
                    r_wdat <= bus.dataWr;
                    r_err  <= 1'b0;
                    r_cnt  <= '0;
                    if (w_isRam)      r_src <= SRC_RAM;
                    else if (w_isPrg) r_src <= SRC_PRG;
                    else begin
                        r_src <= SRC_LAT;
                        r_lat <= r_openBus;
                    end
                    if (w_isPpu) begin
                        r_ppuReq    <= 1'b1;
                        r_ppuAddr   <= bus.addr[2:0];
                        r_ppuWrEn   <= bus.wrEn;
                        r_ppuDataWr <= bus.dataWr;
                    end
                end
                S_PPU_WAIT: begin
                    if (bus.ppuAck) begin
                        r_ppuReq <= 1'b0;
                        r_lat    <= bus.ppuDataRd;
                    end else if (w_timeout) begin
                        r_ppuReq <= 1'b0;
                        r_lat    <= r_openBus;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP:  r_openBus <= r_wr ? r_wdat : w_rdata;
                default: ;
            endcase
        end
    end

    // Work RAM is not reset; its read port is registered on the accepting edge.
    always_ff @(posedge cpuClk) begin
        if (w_accept && w_isRam) begin
            if (bus.wrEn) r_ram[w_ramIdx] <= bus.dataWr;
            else          r_ramQ          <= r_ram[w_ramIdx];
        end
    end

    assign bus.prgAddr   = bus.addr[PRG_AW-1:0];
    assign bus.rdy       = w_rdy;
    assign bus.busErr    = w_busErr;
    assign bus.dataRd    = w_dataRd;
    assign bus.ppuReq    = r_ppuReq;
    assign bus.ppuAddr   = r_ppuAddr;
    assign bus.ppuWrEn   = r_ppuWrEn;
    assign bus.ppuDataWr = r_ppuDataWr;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: directed accesses push expected responses into a scoreboard,
// a monitor pops and checks them on every rdy; a PPU model acks after a programmable delay.
module tb_cpu_bus_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_responder_if #(.PRG_AW(15)) bus ();
    cpu_bus_responder_if #(.PRG_AW(14)) bus14 ();

    cpu_bus_responder #(.RAM_AW(11), .PRG_AW(15), .PPU_TIMEOUT(4)) u_dut (
        .cpuClk (clk),
        .reset  (rst_n),
        .bus    (bus.slave)
    );

    cpu_bus_responder #(.RAM_AW(11), .PRG_AW(14), .PPU_TIMEOUT(4)) u_dut14 (
        .cpuClk (clk),
        .reset  (rst_n),
        .bus    (bus14.slave)
    );

    typedef struct {
        int         id;
        bit         chk;
        logic [7:0] data;
        bit         err;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;

    int         ppu_delay = 0;
    logic [7:0] ppu_rdata = 8'h00;
    bit         inj_ack   = 1'b0;
    int         reqcyc    = 0;
    int         last_len  = 0;
    logic [2:0] cap_addr  = 3'd0;
    logic       cap_wr    = 1'b0;
    logic [7:0] cap_dat   = 8'h00;
    bit         hold_bad  = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every cycle with rdy must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n) begin
                if (bus.rdy) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_rdy: rdy=1 at cycle %0d with no access pending", cyc);
                    end else begin
                        e = sb.pop_front();
                        tests++;
                        if (cyc != e.cyc) begin
                            fails++;
                            $display("FAIL latency id%0d: rdy at cycle %0d expected %0d", e.id, cyc, e.cyc);
                        end
                        tests++;
                        if (bus.busErr !== e.err) begin
                            fails++;
                            $display("FAIL busErr id%0d: got %b expected %b", e.id, bus.busErr, e.err);
                        end
                        if (e.chk) begin
                            tests++;
                            if (bus.dataRd !== e.data) begin
                                fails++;
                                $display("FAIL dataRd id%0d: got %h expected %h", e.id, bus.dataRd, e.data);
                            end
                        end
                    end
                end else begin
                    tests++;
                    if (bus.busErr !== 1'b0 || bus.dataRd !== 8'h00) begin
                        fails++;
                        $display("FAIL idle_outputs: busErr=%b dataRd=%h expected 0/00", bus.busErr, bus.dataRd);
                    end
                end
            end
        end
    end

    // PPU model: acks in the ppu_delay-th request cycle (0 = never), plus injected stray acks.
    initial begin
        bus.ppuAck    = 1'b0;
        bus.ppuDataRd = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.ppuAck = inj_ack;
            if (bus.ppuReq) begin
                reqcyc++;
                last_len = reqcyc;
                if (reqcyc == 1) begin
                    cap_addr = bus.ppuAddr;
                    cap_wr   = bus.ppuWrEn;
                    cap_dat  = bus.ppuDataWr;
                end else if (bus.ppuAddr !== cap_addr || bus.ppuWrEn !== cap_wr || bus.ppuDataWr !== cap_dat) begin
                    hold_bad = 1'b1;
                end
                if (ppu_delay != 0 && reqcyc == ppu_delay) begin
                    bus.ppuAck    = 1'b1;
                    bus.ppuDataRd = ppu_rdata;
                end
            end else begin
                reqcyc = 0;
            end
        end
    end

    task automatic access(input int id, input logic [15:0] a, input bit w, input logic [7:0] wd,
                          input logic [7:0] ed, input bit ee, input int lat, input bit drop);
        int n;
        @(negedge clk);
        bus.addr     = a;
        bus.wrEn     = w;
        bus.dataWr   = wd;
        bus.busValid = 1'b1;
        sb.push_back('{id, !w, ed, ee, cyc + lat});
        if (drop) begin
            @(negedge clk);
            bus.busValid = 1'b0;
            bus.addr     = 16'h4321;
        end
        n = 0;
        while (!bus.rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rdy) begin
            tests++;
            fails++;
            $display("FAIL timeout id%0d: no rdy within 40 cycles", id);
            sb.delete();
        end
        bus.busValid = 1'b0;
        bus.addr     = 16'h2000;
    endtask

    initial begin
        bus.busValid   = 1'b0;
        bus.addr       = 16'h0000;
        bus.wrEn       = 1'b0;
        bus.dataWr     = 8'h00;
        bus.prgData    = 8'h00;
        bus14.busValid = 1'b0;
        bus14.addr     = 16'h0000;
        bus14.wrEn     = 1'b0;
        bus14.dataWr   = 8'h00;
        bus14.prgData  = 8'h00;
        bus14.ppuAck   = 1'b0;
        bus14.ppuDataRd = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_rdy",       {15'd0, bus.rdy},       16'h0000);
        chk("rst_busErr",    {15'd0, bus.busErr},    16'h0000);
        chk("rst_dataRd",    {8'd0, bus.dataRd},     16'h0000);
        chk("rst_ppuReq",    {15'd0, bus.ppuReq},    16'h0000);
        chk("rst_ppuAddr",   {13'd0, bus.ppuAddr},   16'h0000);
        chk("rst_ppuWrEn",   {15'd0, bus.ppuWrEn},   16'h0000);
        chk("rst_ppuDataWr", {8'd0, bus.ppuDataWr},  16'h0000);
        rst_n = 1'b1;

        // RAM write then mirrored reads
        access(1, 16'h0002, 1'b1, 8'hA5, 8'h00, 1'b0, 1, 1'b0);
        access(2, 16'h1802, 1'b0, 8'h00, 8'hA5, 1'b0, 1, 1'b0);
        access(3, 16'h0802, 1'b0, 8'h00, 8'hA5, 1'b0, 1, 1'b0);

        // PRG read and PRG mirroring
        bus.prgData = 8'h34;
        bus.addr    = 16'hFFFC;
        #1 chk("prgAddr15", {1'b0, bus.prgAddr}, 16'h7FFC);
        access(4, 16'hFFFC, 1'b0, 8'h00, 8'h34, 1'b0, 1, 1'b0);
        bus14.addr = 16'hC010;
        #1 chk("prgAddr14", {2'b00, bus14.prgAddr}, 16'h0010);

        // PPU write acked after 3 request cycles
        ppu_delay = 3;
        access(5, 16'h2000, 1'b1, 8'h80, 8'h00, 1'b0, 4, 1'b0);
        chk("ppu_req_len",  16'(last_len),      16'd3);
        chk("ppu_addr_w",   {13'd0, cap_addr},  16'h0000);
        chk("ppu_wren_w",   {15'd0, cap_wr},    16'h0001);
        chk("ppu_data_w",   {8'd0, cap_dat},    16'h0080);
        ppu_rdata = 8'h1F;
        access(6, 16'h3FFA, 1'b0, 8'h00, 8'h1F, 1'b0, 4, 1'b0);
        chk("ppu_addr_r",   {13'd0, cap_addr},  16'h0002);
        chk("ppu_wren_r",   {15'd0, cap_wr},    16'h0000);
        // mirror $3FF9 -> reg 1, CPU drops busValid after accept
        ppu_delay = 1;
        access(7, 16'h3FF9, 1'b0, 8'h00, 8'h1F, 1'b0, 2, 1'b1);
        chk("ppu_addr_mir", {13'd0, cap_addr},  16'h0001);
        chk("ppu_req_len1", 16'(last_len),      16'd1);

        // PPU timeout returns open bus with busErr; ack on the timeout cycle wins
        ppu_delay = 0;
        access(8, 16'h2005, 1'b0, 8'h00, 8'h1F, 1'b1, 5, 1'b0);
        ppu_delay = 4;
        ppu_rdata = 8'h6C;
        access(9, 16'h2001, 1'b0, 8'h00, 8'h6C, 1'b0, 5, 1'b0);
        chk("ppu_hold", {15'd0, hold_bad}, 16'h0000);

        // open bus tracking and dropped writes
        access(10, 16'h0010, 1'b1, 8'h47, 8'h00, 1'b0, 1, 1'b0);
        access(11, 16'h0010, 1'b0, 8'h00, 8'h47, 1'b0, 1, 1'b0);
        access(12, 16'h5000, 1'b0, 8'h00, 8'h47, 1'b0, 1, 1'b0);
        access(13, 16'h8000, 1'b1, 8'h99, 8'h00, 1'b0, 1, 1'b0);
        access(14, 16'h6000, 1'b0, 8'h00, 8'h99, 1'b0, 1, 1'b0);
        access(15, 16'h8000, 1'b0, 8'h00, 8'h34, 1'b0, 1, 1'b0);

        // stray ack while idle is ignored
        @(negedge clk) inj_ack = 1'b1;
        @(negedge clk) inj_ack = 1'b0;
        access(16, 16'h7000, 1'b0, 8'h00, 8'h34, 1'b0, 1, 1'b0);

        // reset during PPU_WAIT, then a late ack
        ppu_delay = 0;
        @(negedge clk);
        bus.addr     = 16'h2003;
        bus.wrEn     = 1'b1;
        bus.dataWr   = 8'h55;
        bus.busValid = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_ppuReq", {15'd0, bus.ppuReq}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("arst_ppuReq",    {15'd0, bus.ppuReq},   16'h0000);
        chk("arst_ppuAddr",   {13'd0, bus.ppuAddr},  16'h0000);
        chk("arst_ppuWrEn",   {15'd0, bus.ppuWrEn},  16'h0000);
        chk("arst_ppuDataWr", {8'd0, bus.ppuDataWr}, 16'h0000);
        chk("arst_rdy",       {15'd0, bus.rdy},      16'h0000);
        bus.busValid = 1'b0;
        bus.wrEn     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk) inj_ack = 1'b1;
        @(negedge clk) inj_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_ppuReq", {15'd0, bus.ppuReq}, 16'h0000);
        access(17, 16'h4000, 1'b0, 8'h00, 8'h00, 1'b0, 1, 1'b0);
        access(18, 16'h0002, 1'b0, 8'h00, 8'hA5, 1'b0, 1, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
